tx_readback_ctrl: RTL and testbench
===================================

// Module: tx_readback_ctrl
// PURPOSE
//  Sequences a memory-to-UART readback: on a start pulse, reads byte_count bytes from the byte
//  memory starting at base_addr and hands each one to async_transmitter, one byte per frame,
//  pacing on TxD_busy. Sits beside control inside comm; owns the memory read port and TxD_start.
// PARAMETERS
//  ADDR_W   16  memory address width (matches control/memory pointers)
//  DATA_W   8   memory word / UART byte width
// PORTS
//  clk         in   1         system clock; all logic on rising edge
//  reset       in   1         synchronous, active-high reset
//  start       in   1         1-cycle request; sampled only in IDLE
//  abort       in   1         stop after the byte currently on the wire; then done
//  base_addr   in   ADDR_W    first address, captured on accepted start
//  byte_count  in   ADDR_W+1  bytes to send, 0..2^ADDR_W, captured on accepted start
//  rd_en       out  1         memory read strobe (1 cycle)
//  rd_addr     out  ADDR_W    memory read address
//  rd_data     in   DATA_W    memory read data, valid exactly 1 cycle after rd_en
//  tx_start    out  1         to TxD_start; 1-cycle pulse
//  tx_data     out  DATA_W    to transmitter data; held stable from tx_start until next load
//  tx_busy     in   1         from TxD_busy
//  busy        out  1         high in every state except IDLE
//  done        out  1         1-cycle pulse on completion/abort/zero length
//  bytes_sent  out  ADDR_W+1  frames fully transmitted in current/last transfer
// BEHAVIOUR
//  Reset: state=IDLE; rd_en=0, tx_start=0, busy=0, done=0; rd_addr=0, tx_data=0, bytes_sent=0.
//  States: IDLE, READ, LATCH, SEND, ACK, DRAIN, FINISH.
//  IDLE:  start=1 -> capture addr<=base_addr, remaining<=byte_count, bytes_sent<=0;
//         remaining==0 -> FINISH, else READ. start outside IDLE ignored (no queueing).
//  READ:  rd_en=1, rd_addr=addr for one cycle -> LATCH.
//  LATCH: tx_data<=rd_data; addr<=addr+1 (mod 2^ADDR_W, wraps 0xFFFF->0x0000) -> SEND.
//  SEND:  if tx_busy=0: tx_start=1 for one cycle -> ACK; else hold (no pulse).
//  ACK:   wait for tx_busy=1 -> DRAIN. Transmitter raises busy the cycle after TxD_start;
//         if busy not seen within 2 cycles, treat byte as sent -> DRAIN (no stall).
//  DRAIN: wait tx_busy=0; then bytes_sent+=1, remaining-=1;
//         remaining(after dec)==0 or abort_latched -> FINISH, else READ.
//  FINISH: done=1 for one cycle -> IDLE (busy drops the same cycle done is seen low).
//  abort: any cycle with busy=1 sets abort_latched (cleared in IDLE). In READ/LATCH/SEND
//         (byte not yet started) -> FINISH next cycle without tx_start; in ACK/DRAIN the
//         current frame completes and is counted, then FINISH. abort in IDLE ignored.
//  Timing: start -> first tx_start = 3 cycles min (READ, LATCH, SEND) when tx_busy=0.
//         Inter-byte gap after tx_busy falls: 3 cycles to next tx_start.
//  Simultaneous start+abort in IDLE: start accepted, abort ignored.
//  Reset mid-transfer: immediate IDLE next edge; tx_start never left high; partial count lost.
//  Full length 2^ADDR_W: byte_count=0x10000 sends every address once, ending with wrap.
//  At most one tx_start per byte; never asserted while tx_busy=1.
// TESTING
//  1 base=0x0010,count=3, mem[0x10..12]=A5,3C,FF, transmitter model busy 10 cyc -> tx_data
//    A5,3C,FF in order, 3 tx_start pulses, done once, bytes_sent=3, busy low after done.
//  2 count=0 -> no rd_en, no tx_start, done 1 cycle after start (FINISH), bytes_sent=0.
//  3 base=0xFFFE,count=4 -> rd_addr sequence FFFE,FFFF,0000,0001; bytes_sent=4.
//  4 abort pulsed mid-DRAIN of byte 2 of 5 -> byte 2 completes, no 3rd tx_start,
//    done pulse, bytes_sent=2; abort in SEND of byte 1 -> 0 tx_start, bytes_sent=0.
//  5 tx_busy held high at start for 20 cycles -> stays in SEND, tx_start pulses only
//    after busy drops; second start during transfer ignored (count unchanged).
//  6 reset asserted in ACK -> next cycle busy=0, tx_start=0, rd_en=0; new start works.

Source files
------------

// File: rtl/tx_readback_ctrl.sv
// Memory-to-UART readback sequencer: streams byte_count bytes from base_addr to the
// transmitter, one frame per byte, pacing on the transmitter busy flag.
module tx_readback_ctrl #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   byte_count,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              tx_start,
    output logic [DATA_W-1:0] tx_data,
    input  logic              tx_busy,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   bytes_sent
);

    typedef enum logic [2:0] {
        S_IDLE, S_READ, S_LATCH, S_SEND, S_ACK, S_DRAIN, S_FINISH
    } state_t;

    localparam logic [ADDR_W-1:0] ONE_A = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   ONE_C = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   ZERO_C = '0;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W:0]     remaining_q, remaining_d;
    logic [ADDR_W:0]     sent_q, sent_d;
    logic [DATA_W-1:0]   txd_q, txd_d;
    logic                abort_q, abort_d;
    logic                ack_wait_q, ack_wait_d;
    logic                abort_now;

    // An abort pulse acts in the cycle it arrives as well as after it is latched.
    assign abort_now = abort_q | abort;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            sent_q      <= '0;
            txd_q       <= '0;
            abort_q     <= 1'b0;
            ack_wait_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            sent_q      <= sent_d;
            txd_q       <= txd_d;
            abort_q     <= abort_d;
            ack_wait_q  <= ack_wait_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        sent_d      = sent_q;
        txd_d       = txd_q;
        abort_d     = abort_now;
        ack_wait_d  = ack_wait_q;

        case (state_q)
            S_IDLE: begin
                abort_d = 1'b0;
                if (start) begin
                    addr_d      = base_addr;
                    remaining_d = byte_count;
                    sent_d      = '0;
                    state_d     = (byte_count == ZERO_C) ? S_FINISH : S_READ;
                end
            end
            S_READ: begin
                state_d = abort_now ? S_FINISH : S_LATCH;
            end
            S_LATCH: begin
                txd_d   = rd_data;
                addr_d  = addr_q + ONE_A;
                state_d = abort_now ? S_FINISH : S_SEND;
            end
            S_SEND: begin
                if (abort_now) begin
                    state_d = S_FINISH;
                end else if (!tx_busy) begin
                    ack_wait_d = 1'b0;
                    state_d    = S_ACK;
                end
            end
            S_ACK: begin
                // A transmitter that never raises busy must not stall the transfer.
                if (tx_busy || ack_wait_q) begin
                    state_d = S_DRAIN;
                end else begin
                    ack_wait_d = 1'b1;
                end
            end
            S_DRAIN: begin
                if (!tx_busy) begin
                    sent_d      = sent_q + ONE_C;
                    remaining_d = remaining_q - ONE_C;
                    state_d     = (remaining_q == ONE_C || abort_now) ? S_FINISH : S_READ;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        rd_en    = (state_q == S_READ);
        tx_start = (state_q == S_SEND) && !tx_busy && !abort_now;
        busy     = (state_q != S_IDLE);
        done     = (state_q == S_FINISH);
    end

    assign rd_addr    = addr_q;
    assign tx_data    = txd_q;
    assign bytes_sent = sent_q;

endmodule

// File: tb/tb_tx_readback_ctrl.sv
// Directed bench for tx_readback_ctrl with a byte memory and a simple transmitter model.
module tb_tx_readback_ctrl;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 8;
    localparam int BUSY_LEN = 10;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              abort;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   byte_count;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data = '0;
    logic              tx_start;
    logic [DATA_W-1:0] tx_data;
    logic              tx_busy;
    logic              busy;
    logic              done;
    logic [ADDR_W:0]   bytes_sent;

    logic [7:0] mem [0:65535];
    logic       mdl_busy = 1'b0;
    int         mdl_cnt = 0;
    logic       force_busy;
    logic       xmit_en;

    int         n_tx = 0;
    int         n_done = 0;
    int         n_viol = 0;
    logic [7:0] txq[$];
    logic [15:0] addrq[$];

    int chk = 0;
    int pass = 0;

    always #5 clk = ~clk;

    tx_readback_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .base_addr(base_addr), .byte_count(byte_count),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
        .busy(busy), .done(done), .bytes_sent(bytes_sent)
    );

    assign tx_busy = mdl_busy | force_busy;

    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
    end

    // Transmitter: busy rises the cycle after tx_start and stays high BUSY_LEN cycles.
    always @(posedge clk) begin
        if (tx_start && xmit_en) begin
            mdl_busy <= 1'b1;
            mdl_cnt  <= BUSY_LEN - 1;
        end else if (mdl_cnt != 0) begin
            mdl_cnt <= mdl_cnt - 1;
        end else begin
            mdl_busy <= 1'b0;
        end
    end

    always @(posedge clk) begin
        if (tx_start) begin
            n_tx <= n_tx + 1;
            txq.push_back(tx_data);
            if (tx_busy) n_viol <= n_viol + 1;
        end
        if (rd_en) addrq.push_back(rd_addr);
        if (done) n_done <= n_done + 1;
    end

    task automatic do_start(input logic [15:0] b, input logic [16:0] c);
        @(negedge clk);
        start = 1'b1;
        base_addr = b;
        byte_count = c;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass++;
        chk++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else pass++;
        chk++; if (rd_en !== 1'b0) $display("FAIL reset_rd_en: got %b want 0", rd_en); else pass++;
        chk++; if (tx_start !== 1'b0) $display("FAIL reset_tx_start: got %b want 0", tx_start); else pass++;
        chk++; if (rd_addr !== 16'h0000) $display("FAIL reset_rd_addr: got %h want 0000", rd_addr); else pass++;
        chk++; if (tx_data !== 8'h00) $display("FAIL reset_tx_data: got %h want 00", tx_data); else pass++;
        chk++; if (bytes_sent !== 17'h0) $display("FAIL reset_bytes_sent: got %0d want 0", bytes_sent); else pass++;
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic;
        int t0, d0;
        bit ok;
        t0 = n_tx; d0 = n_done;
        do_start(16'h0010, 17'd3);
        chk++; if (rd_en !== 1'b1 || rd_addr !== 16'h0010) $display("FAIL basic_first_read: got en=%b addr=%h want en=1 addr=0010", rd_en, rd_addr); else pass++;
        repeat (2) @(negedge clk);
        chk++; if (tx_start !== 1'b1 || tx_data !== 8'hA5) $display("FAIL basic_first_tx: got start=%b data=%h want start=1 data=a5", tx_start, tx_data); else pass++;
        wait_done(300, ok);
        chk++; if (!ok) $display("FAIL basic_done_timeout: got no done want done"); else pass++;
        chk++; if (bytes_sent !== 17'd3) $display("FAIL basic_bytes_sent: got %0d want 3", bytes_sent); else pass++;
        @(negedge clk);
        chk++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL basic_after_done: got busy=%b done=%b want 0 0", busy, done); else pass++;
        chk++; if (n_tx - t0 !== 3) $display("FAIL basic_tx_count: got %0d want 3", n_tx - t0); else pass++;
        chk++; if (n_done - d0 !== 1) $display("FAIL basic_done_count: got %0d want 1", n_done - d0); else pass++;
        chk++; if (txq[t0+1] !== 8'h3C || txq[t0+2] !== 8'hFF) $display("FAIL basic_tx_order: got %h %h want 3c ff", txq[t0+1], txq[t0+2]); else pass++;
    endtask

    task automatic test_zero_length;
        int t0, a0;
        t0 = n_tx; a0 = addrq.size();
        do_start(16'h0040, 17'd0);
        chk++; if (done !== 1'b1) $display("FAIL zero_done: got %b want 1", done); else pass++;
        @(negedge clk);
        chk++; if (n_tx - t0 !== 0 || addrq.size() - a0 !== 0) $display("FAIL zero_no_activity: got tx=%0d rd=%0d want 0 0", n_tx - t0, addrq.size() - a0); else pass++;
        chk++; if (bytes_sent !== 17'd0 || busy !== 1'b0) $display("FAIL zero_state: got sent=%0d busy=%b want 0 0", bytes_sent, busy); else pass++;
    endtask

    task automatic test_wrap;
        int a0;
        bit ok;
        a0 = addrq.size();
        do_start(16'hFFFE, 17'd4);
        wait_done(400, ok);
        chk++; if (!ok) $display("FAIL wrap_done_timeout: got no done want done"); else pass++;
        chk++; if (bytes_sent !== 17'd4) $display("FAIL wrap_bytes_sent: got %0d want 4", bytes_sent); else pass++;
        chk++; if (addrq[a0] !== 16'hFFFE || addrq[a0+1] !== 16'hFFFF || addrq[a0+2] !== 16'h0000 || addrq[a0+3] !== 16'h0001)
            $display("FAIL wrap_addr_seq: got %h %h %h %h want fffe ffff 0000 0001", addrq[a0], addrq[a0+1], addrq[a0+2], addrq[a0+3]);
        else pass++;
        @(negedge clk);
    endtask

    task automatic test_abort;
        int t0, d0;
        bit ok;
        t0 = n_tx; d0 = n_done;
        do_start(16'h0020, 17'd5);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (n_tx - t0 >= 2) begin ok = 1'b1; break; end
        end
        chk++; if (!ok) $display("FAIL abort_second_tx_timeout: got %0d tx want 2", n_tx - t0); else pass++;
        repeat (5) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        wait_done(200, ok);
        chk++; if (!ok) $display("FAIL abort_drain_done_timeout: got no done want done"); else pass++;
        chk++; if (bytes_sent !== 17'd2) $display("FAIL abort_drain_sent: got %0d want 2", bytes_sent); else pass++;
        @(negedge clk);
        chk++; if (n_tx - t0 !== 2 || n_done - d0 !== 1) $display("FAIL abort_drain_counts: got tx=%0d done=%0d want 2 1", n_tx - t0, n_done - d0); else pass++;

        t0 = n_tx;
        force_busy = 1'b1;
        do_start(16'h0020, 17'd5);
        repeat (4) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk++; if (done !== 1'b1) $display("FAIL abort_send_done: got %b want 1", done); else pass++;
        force_busy = 1'b0;
        @(negedge clk);
        chk++; if (n_tx - t0 !== 0 || bytes_sent !== 17'd0) $display("FAIL abort_send_state: got tx=%0d sent=%0d want 0 0", n_tx - t0, bytes_sent); else pass++;
    endtask

    task automatic test_busy_hold;
        int t0;
        bit ok;
        t0 = n_tx;
        force_busy = 1'b1;
        do_start(16'h0010, 17'd2);
        repeat (5) @(negedge clk);
        do_start(16'h0000, 17'd7);
        repeat (13) @(negedge clk);
        chk++; if (n_tx - t0 !== 0 || busy !== 1'b1) $display("FAIL hold_no_tx: got tx=%0d busy=%b want 0 1", n_tx - t0, busy); else pass++;
        force_busy = 1'b0;
        wait_done(300, ok);
        chk++; if (!ok) $display("FAIL hold_done_timeout: got no done want done"); else pass++;
        chk++; if (bytes_sent !== 17'd2) $display("FAIL hold_bytes_sent: got %0d want 2", bytes_sent); else pass++;
        @(negedge clk);
        chk++; if (n_tx - t0 !== 2 || txq[t0] !== 8'hA5 || txq[t0+1] !== 8'h3C) $display("FAIL hold_tx_data: got n=%0d %h %h want 2 a5 3c", n_tx - t0, txq[t0], txq[t0+1]); else pass++;
        chk++; if (n_viol !== 0) $display("FAIL tx_start_while_busy: got %0d want 0", n_viol); else pass++;
    endtask

    task automatic test_ack_timeout;
        int t0;
        bit ok;
        t0 = n_tx;
        xmit_en = 1'b0;
        do_start(16'h0010, 17'd2);
        wait_done(60, ok);
        chk++; if (!ok) $display("FAIL ack_timeout_done: got no done want done"); else pass++;
        chk++; if (bytes_sent !== 17'd2) $display("FAIL ack_timeout_sent: got %0d want 2", bytes_sent); else pass++;
        @(negedge clk);
        chk++; if (n_tx - t0 !== 2) $display("FAIL ack_timeout_tx: got %0d want 2", n_tx - t0); else pass++;
        xmit_en = 1'b1;
    endtask

    task automatic test_reset_mid;
        int t0;
        bit ok;
        t0 = n_tx;
        do_start(16'h0010, 17'd3);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (tx_start) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        chk++; if (!ok) $display("FAIL rst_mid_first_tx: got none want tx_start"); else pass++;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk++; if (busy !== 1'b0 || tx_start !== 1'b0 || rd_en !== 1'b0) $display("FAIL rst_mid_state: got busy=%b txs=%b rd=%b want 0 0 0", busy, tx_start, rd_en); else pass++;
        reset = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!tx_busy) begin ok = 1'b1; break; end
        end
        chk++; if (!ok) $display("FAIL rst_mid_idle_line: got busy want idle"); else pass++;
        t0 = n_tx;
        do_start(16'h0012, 17'd1);
        wait_done(100, ok);
        chk++; if (!ok || bytes_sent !== 17'd1) $display("FAIL rst_mid_restart: got done=%b sent=%0d want 1 1", ok, bytes_sent); else pass++;
        @(negedge clk);
        chk++; if (n_tx - t0 !== 1 || txq[t0] !== 8'hFF) $display("FAIL rst_mid_restart_data: got n=%0d %h want 1 ff", n_tx - t0, txq[t0]); else pass++;
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        base_addr = '0;
        byte_count = '0;
        force_busy = 1'b0;
        xmit_en = 1'b1;
        for (int i = 0; i < 65536; i++) mem[i] = 8'(i) ^ 8'h5A;
        mem[16'h0010] = 8'hA5;
        mem[16'h0011] = 8'h3C;
        mem[16'h0012] = 8'hFF;

        test_reset();
        test_basic();
        test_zero_length();
        test_wrap();
        test_abort();
        test_busy_hold();
        test_ack_timeout();
        test_reset_mid();

        $display("%0d/%0d checks passed", pass, chk);
        $finish;
    end

endmodule
